piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 132 +++++++++++++
 tb/tb_piso_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding and a width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on load, advanced once per enabled clk_en tick.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          clk_en,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && clk_en) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, one bit per clk_en tick.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load_accept;
    logic             frame_end;

`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    assign load_accept = (state == ST_IDLE) && load_valid;
    assign load_ready  = (state == ST_IDLE) && !rst;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_accept),
        .en    (state == ST_SHIFT),
        .clk_en(clk_en),
        .count (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        frame_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = shreg[WIDTH-1];
                if (clk_en && last) begin
`ifdef PISO_PARITY_EN
                    next_state = ST_PAR;
`else
                    next_state = ST_IDLE;
                    frame_end  = 1'b1;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = parity;
                if (clk_en) begin
                    next_state = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
`endif
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Shift only on a tick so each bit stays on sout until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (load_accept) begin
            shreg <= data_in;
        end else if (state == ST_SHIFT && clk_en) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (load_accept) begin
            parity <= ^data_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= frame_end;
        end
    end

    // The counter must leave SHIFT before it could step past the last bit.
    assert property (@(posedge clk) disable iff (rst)
        (state == ST_SHIFT) |-> (cnt < CW'(WIDTH)));

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (WIDTH=4) with a SIPO loopback.
// Honours PISO_PARITY_EN to expect the trailing parity bit.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] data_in;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [FL-1:0] sipo;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0] data;
        int         period;
        logic [3:0] exp_bits;
        logic       exp_par;
        bit         poke_busy;
    } vec_t;

    vec_t vecs [5];

    piso_serializer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .data_in   (data_in),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Receiving SIPO, enabled exactly as the link partner would be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sipo <= '0;
        end else if (sout_valid && clk_en) begin
            sipo <= {sipo[FL-2:0], sout};
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int  bit_idx;
        logic exp_bit;
        checkOutput("idle_load_ready", 8'(load_ready), 8'd1);
        data_in    = v.data;
        load_valid = 1'b1;
        clk_en     = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        data_in    = 4'h0;
        for (int k = 0; k < FL * v.period; k++) begin
            bit_idx = k / v.period;
            exp_bit = (bit_idx < 4) ? v.exp_bits[3 - bit_idx] : v.exp_par;
            checkOutput("sout", 8'(sout), 8'(exp_bit));
            checkOutput("sout_valid", 8'(sout_valid), 8'd1);
            checkOutput("busy", 8'(busy), 8'd1);
            checkOutput("done_early", 8'(done), 8'd0);
            if (v.poke_busy && k == 1) begin
                checkOutput("busy_load_ready", 8'(load_ready), 8'd0);
                load_valid = 1'b1;
                data_in    = 4'b0000;
            end else begin
                load_valid = 1'b0;
            end
            clk_en = ((k % v.period) == v.period - 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        clk_en     = 1'b0;
        checkOutput("done_pulse", 8'(done), 8'd1);
        checkOutput("done_load_ready", 8'(load_ready), 8'd1);
        checkOutput("done_busy", 8'(busy), 8'd0);
        checkOutput("done_sout_valid", 8'(sout_valid), 8'd0);
`ifdef PISO_PARITY_EN
        checkOutput("loopback", 8'(sipo), 8'({v.exp_bits, v.exp_par}));
`else
        checkOutput("loopback", 8'(sipo), 8'(v.exp_bits));
`endif
        @(negedge clk);
        checkOutput("done_one_cycle", 8'(done), 8'd0);
    endtask

    initial begin
        vecs[0] = '{data: 4'b1011, period: 1, exp_bits: 4'b1011, exp_par: 1'b1, poke_busy: 1'b0};
        vecs[1] = '{data: 4'b0110, period: 3, exp_bits: 4'b0110, exp_par: 1'b0, poke_busy: 1'b0};
        vecs[2] = '{data: 4'b1111, period: 1, exp_bits: 4'b1111, exp_par: 1'b0, poke_busy: 1'b1};
        vecs[3] = '{data: 4'b1101, period: 1, exp_bits: 4'b1101, exp_par: 1'b1, poke_busy: 1'b0};
        vecs[4] = '{data: 4'b0000, period: 2, exp_bits: 4'b0000, exp_par: 1'b0, poke_busy: 1'b1};

        rst        = 1'b1;
        clk_en     = 1'b0;
        load_valid = 1'b0;
        data_in    = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_sout", 8'(sout), 8'd0);
            checkOutput("rst_sout_valid", 8'(sout_valid), 8'd0);
            checkOutput("rst_busy", 8'(busy), 8'd0);
            checkOutput("rst_done", 8'(done), 8'd0);
            checkOutput("rst_load_ready", 8'(load_ready), 8'd0);
        end
        rst = 1'b0;
        #1;
        checkOutput("post_rst_load_ready", 8'(load_ready), 8'd1);
        checkOutput("post_rst_busy", 8'(busy), 8'd0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Abort in the middle of bit 2 of a strobed frame, with a load offered during reset.
        data_in    = 4'b1111;
        load_valid = 1'b1;
        clk_en     = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            clk_en = ((k % 3) == 2);
            @(negedge clk);
        end
        checkOutput("pre_abort_sout", 8'(sout), 8'd1);
        checkOutput("pre_abort_busy", 8'(busy), 8'd1);
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 4'b0101;
        #1;
        checkOutput("abort_sout", 8'(sout), 8'd0);
        checkOutput("abort_sout_valid", 8'(sout_valid), 8'd0);
        checkOutput("abort_busy", 8'(busy), 8'd0);
        checkOutput("abort_load_ready", 8'(load_ready), 8'd0);
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        clk_en     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 8'(done), 8'd0);
            checkOutput("abort_not_loaded", 8'(busy), 8'd0);
        end

        applyStimulus('{data: 4'b1001, period: 1, exp_bits: 4'b1001, exp_par: 1'b0, poke_busy: 1'b0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
